pixel_frame_sink: RTL and testbench
===================================

PIXEL_FRAME_SINK -- requirements
Module: pixel_frame_sink

Interface
REQ-001 SHALL have parameter H_RES, default 320, logical framebuffer width in pixels.
REQ-002 SHALL have parameter V_RES, default 240, logical framebuffer height in pixels.
REQ-003 SHALL have parameter CLEAR_COLOUR, default 3'b111, fill value used by clear.
REQ-004 SHALL have port clock  in  1  pixel clock, 25 MHz, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high.
REQ-006 SHALL have port plot  in  1  pixel write strobe.
REQ-007 SHALL have port x  in  9  write column.
REQ-008 SHALL have port y  in  8  write row.
REQ-009 SHALL have port colour  in  3  write colour {R,G,B}.
REQ-010 SHALL have port clear  in  1  start full-frame fill with CLEAR_COLOUR.
REQ-011 SHALL have port ready  out  1  high when plot writes are accepted.
REQ-012 SHALL have port vga_hsync  out  1  active-low horizontal sync.
REQ-013 SHALL have port vga_vsync  out  1  active-low vertical sync.
REQ-014 SHALL have port vga_blank_n  out  1  high during visible region.
REQ-015 SHALL have port vga_colour  out  3  displayed pixel colour.
REQ-016 SHALL have port frame_start  out  1  one-cycle pulse at start of each frame.

Function
REQ-017 SHALL hold an H_RES*V_RES x 3-bit framebuffer, address = y*H_RES + x, one write port, one read port, registered read (1-cycle latency).
REQ-018 SHALL write colour to (x,y) on the edge after plot=1 and ready=1 when x<H_RES and y<V_RES.
REQ-019 SHALL discard plot when x>=H_RES or y>=V_RES, with no side effect.
REQ-020 SHALL discard plot while ready=0; no queuing.
REQ-021 SHALL implement a write FSM with states IDLE and CLEAR; ready=1 in IDLE, 0 in CLEAR.
REQ-022 SHALL go IDLE->CLEAR on clear=1, with a fill counter starting at 0.
REQ-023 SHALL write CLEAR_COLOUR at fill-counter address each CLEAR cycle, incrementing by 1.
REQ-024 SHALL return CLEAR->IDLE the cycle after address H_RES*V_RES-1 is written (76800 write cycles at defaults); ready=1 from that cycle.
REQ-025 SHALL ignore clear while in CLEAR, without restarting the fill.
REQ-026 SHALL, when clear and plot assert together in IDLE, give clear priority and drop the plot.
REQ-027 SHALL run horizontal counter h 0..799, wrapping to 0, and vertical counter v 0..524, incrementing when h wraps and wrapping to 0 after 524.
REQ-028 SHALL define visible as h<640 and v<480; hsync low for h 656..751; vsync low for v 490..491.
REQ-029 SHALL read framebuffer address (v>>1)*H_RES + (h>>1), each logical pixel shown 2x2.
REQ-030 SHALL delay hsync, vsync and blank_n by 2 cycles, matching the read-plus-output-register latency, so vga_colour aligns with the h/v position that produced it.
REQ-031 SHALL drive vga_colour=3'b000 whenever the aligned blank_n=0.
REQ-032 SHALL pulse frame_start for one cycle when h=0 and v=0, undelayed.
REQ-033 SHALL return old data on the read port when a write and a read hit the same address in one cycle; new data on later reads.
REQ-034 SHALL keep scan-out running independently of writes and clear, with no stalls.

Reset
REQ-035 SHALL on reset set h=0, v=0, FSM=IDLE, fill counter=0, ready=1.
REQ-036 SHALL on reset set vga_hsync=1, vga_vsync=1, vga_blank_n=0, vga_colour=0, frame_start=0, and clear the delay pipeline to the same inactive values.
REQ-037 SHALL abort an active clear on reset; framebuffer contents are not reset.
REQ-038 SHALL treat plot and clear asserted during reset as ignored.

Verification
REQ-039 SHALL verify: reset, then 800*525 cycles -> frame_start pulses at cycle 0 and cycle 420000; hsync low 96 cycles per line; vsync low 2 lines.
REQ-040 SHALL verify: plot x=5,y=3,colour=3'b100 -> vga_colour=3'b100 at h=10..11, v=6..7, appearing 2 cycles after those positions.
REQ-041 SHALL verify: plot x=320,y=0 and x=0,y=240 -> framebuffer unchanged.
REQ-042 SHALL verify: clear pulse -> ready=0 for exactly 76800 cycles; plots then dropped; afterwards all visible pixels =3'b111.
REQ-043 SHALL verify: reset asserted at fill count 1000 -> ready=1 next cycle; addresses >=1000 keep prior contents.
REQ-044 SHALL verify: clear and plot in the same cycle -> plot dropped; second clear mid-fill -> total fill length still 76800.

Source files
------------

// File: rtl/pixel_frame_sink.sv
// rtl/pixel_frame_sink.sv - 3-bit framebuffer with plot/clear write FSM and 640x480 VGA scan-out
module pixel_frame_sink #(
   parameter int         H_RES        = 320,
   parameter int         V_RES        = 240,
   parameter logic [2:0] CLEAR_COLOUR = 3'b111
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       plot,
   input  logic [8:0] x,
   input  logic [7:0] y,
   input  logic [2:0] colour,
   input  logic       clear,
   output logic       ready,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic       vga_blank_n,
   output logic [2:0] vga_colour,
   output logic       frame_start
);

   localparam int DEPTH = H_RES * V_RES;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} stateT;

   stateT         state;
   logic [AW-1:0] fillCount;
   logic [2:0]    frameBuffer [DEPTH];

   logic          inRange;
   logic [AW-1:0] plotAddr;
   logic          wrEn;
   logic [AW-1:0] wrAddr;
   logic [2:0]    wrData;

   logic [9:0]    h;
   logic [9:0]    v;
   logic          visible;
   logic          inFrameBuffer;
   logic          hsyncRaw;
   logic          vsyncRaw;
   logic [AW-1:0] rdAddr;
   logic [2:0]    rdData;
   logic          hsyncDly;
   logic          vsyncDly;
   logic          blankDly;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         fillCount <= '0;
         ready     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  state     <= CLEAR;
                  fillCount <= '0;
                  ready     <= 1'b0;
               end
            end
            CLEAR: begin
               if (fillCount == LAST_ADDR) begin
                  state     <= IDLE;
                  fillCount <= '0;
                  ready     <= 1'b1;
               end else begin
                  fillCount <= fillCount + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   assign inRange  = (32'(x) < H_RES) && (32'(y) < V_RES);
   assign plotAddr = AW'(y) * AW'(H_RES) + AW'(x);

   // Clear owns the write port for the whole fill; a plot coinciding with clear is dropped.
   always_comb begin
      wrEn   = 1'b0;
      wrAddr = plotAddr;
      wrData = colour;
      if (!reset) begin
         if (state == CLEAR) begin
            wrEn   = 1'b1;
            wrAddr = fillCount;
            wrData = CLEAR_COLOUR;
         end else if (plot && !clear && inRange) begin
            wrEn = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wrEn) frameBuffer[wrAddr] <= wrData;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (h == 10'd799) begin
         h <= '0;
         v <= (v == 10'd524) ? 10'd0 : v + 10'd1;
      end else begin
         h <= h + 10'd1;
      end
   end

   assign visible       = (h < 10'd640) && (v < 10'd480);
   assign hsyncRaw      = !((h >= 10'd656) && (h <= 10'd751));
   assign vsyncRaw      = !((v >= 10'd490) && (v <= 10'd491));
   assign inFrameBuffer = (32'(h[9:1]) < H_RES) && (32'(v[9:1]) < V_RES);
   assign rdAddr        = inFrameBuffer ? AW'(v[9:1]) * AW'(H_RES) + AW'(h[9:1]) : '0;
   assign frame_start   = !reset && (h == 10'd0) && (v == 10'd0);

   // Read-before-write on a same-address collision falls out of the separate registered read.
   always_ff @(posedge clock) begin
      rdData <= frameBuffer[rdAddr];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hsyncDly    <= 1'b1;
         vsyncDly    <= 1'b1;
         blankDly    <= 1'b0;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_colour  <= 3'b000;
      end else begin
         hsyncDly    <= hsyncRaw;
         vsyncDly    <= vsyncRaw;
         blankDly    <= visible;
         vga_hsync   <= hsyncDly;
         vga_vsync   <= vsyncDly;
         vga_blank_n <= blankDly;
         vga_colour  <= blankDly ? rdData : 3'b000;
      end
   end

endmodule

// File: tb/tb_pixel_frame_sink.sv
// tb/tb_pixel_frame_sink.sv - randomized plot/clear stimulus checked against a pixel-array model of the display
module tb_pixel_frame_sink;

   localparam int HR    = 40;
   localparam int VR    = 6;
   localparam int DEPTH = HR * VR;

   logic       clock = 1'b0;
   logic       reset;
   logic       plot;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       clear;
   logic       ready;
   logic       vga_hsync;
   logic       vga_vsync;
   logic       vga_blank_n;
   logic [2:0] vga_colour;
   logic       frame_start;

   int checks = 0;
   int errors = 0;
   int fb [DEPTH];
   int len;

   pixel_frame_sink #(.H_RES(HR), .V_RES(VR), .CLEAR_COLOUR(3'b111)) dut (
      .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
      .clear(clear), .ready(ready), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vga_blank_n(vga_blank_n), .vga_colour(vga_colour), .frame_start(frame_start)
   );

   always #20 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // Plot and clear are held high throughout reset; neither may take effect.
   task automatic doReset();
      reset = 1'b1; plot = 1'b1; clear = 1'b1; x = 9'd1; y = 8'd1; colour = 3'b001;
      repeat (3) tick();
      #1;
      check("reset_ready", ready, 1);
      check("reset_hsync", vga_hsync, 1);
      check("reset_vsync", vga_vsync, 1);
      check("reset_blank_n", vga_blank_n, 0);
      check("reset_colour", vga_colour, 0);
      check("reset_frame_start", frame_start, 0);
      tick();
      reset = 1'b0; plot = 1'b0; clear = 1'b0;
   endtask

   // Cycle c after reset scans position c; outputs at cycle c describe position c-2.
   task automatic scanCheck(input int n);
      int q, hq, vq, idx, lowCount;
      logic vis;
      lowCount = 0;
      for (int c = 0; c < n; c++) begin
         #1;
         check("frame_start", frame_start, (c % 420000) == 0);
         q = c - 2;
         if (q < 0) begin
            check("pipe_hsync", vga_hsync, 1);
            check("pipe_vsync", vga_vsync, 1);
            check("pipe_blank_n", vga_blank_n, 0);
            check("pipe_colour", vga_colour, 0);
         end else begin
            hq  = q % 800;
            vq  = (q / 800) % 525;
            vis = (hq < 640) && (vq < 480);
            check("hsync", vga_hsync, !(hq >= 656 && hq <= 751));
            check("vsync", vga_vsync, !(vq >= 490 && vq <= 491));
            check("blank_n", vga_blank_n, vis);
            if (!vis) begin
               check("blank_colour", vga_colour, 0);
            end else if ((hq / 2) < HR && (vq / 2) < VR) begin
               idx = (vq / 2) * HR + hq / 2;
               if (fb[idx] >= 0) check("pixel", vga_colour, fb[idx]);
            end
            if (vq == 0 && !vga_hsync) lowCount++;
         end
         tick();
      end
      if (n >= 802) check("hsync_low_cycles", lowCount, 96);
   endtask

   task automatic doPlot(input int xx, input int yy, input int cc);
      x = 9'(xx); y = 8'(yy); colour = 3'(cc); plot = 1'b1;
      #1;
      check("ready_idle", ready, 1);
      tick();
      plot = 1'b0;
      if (xx < HR && yy < VR) fb[yy * HR + xx] = cc;
   endtask

   // Counts ready-low cycles while throwing plots (and optionally a second clear) at the busy sink.
   task automatic clearRun(input bit midClear, output int n);
      clear = 1'b1; plot = 1'b0;
      tick();
      clear = 1'b0;
      n = 0;
      while (ready === 1'b0 && n < 2 * DEPTH + 10) begin
         plot   = (n % 5) == 2;
         x      = 9'($urandom_range(0, HR - 1));
         y      = 8'($urandom_range(0, VR - 1));
         colour = 3'($urandom_range(0, 6));
         clear  = midClear && (n == DEPTH / 2);
         n++;
         tick();
      end
      plot = 1'b0; clear = 1'b0;
      for (int i = 0; i < DEPTH; i++) fb[i] = 7;
   endtask

   initial begin
      reset = 1'b1; plot = 1'b0; clear = 1'b0; x = '0; y = '0; colour = '0;
      for (int i = 0; i < DEPTH; i++) fb[i] = -1;

      doReset();
      scanCheck(1700);

      clearRun(1'b0, len);
      check("clear_length", len, DEPTH);

      doPlot(HR, 0, 1);
      doPlot(0, VR, 2);
      doPlot(320, 0, 3);
      doPlot(0, 240, 4);
      repeat (60) doPlot($urandom_range(0, HR + 2), $urandom_range(0, VR + 1), $urandom_range(0, 7));
      doPlot(HR - 1, VR - 1, 5);
      doPlot(5, 3, 4);
      doReset();
      scanCheck(2 * VR * 800 + 2);

      clear = 1'b1; plot = 1'b1; x = 9'(HR - 1); y = 8'(VR - 1); colour = 3'b010;
      tick();
      clear = 1'b0; plot = 1'b0;
      repeat (100) tick();
      #1;
      check("ready_mid_fill", ready, 0);
      reset = 1'b1;
      tick();
      #1;
      check("ready_after_abort", ready, 1);
      for (int i = 0; i < 100; i++) fb[i] = 7;
      doReset();
      scanCheck(2 * VR * 800 + 2);

      clearRun(1'b1, len);
      check("clear_length_reclear", len, DEPTH);
      doReset();
      scanCheck(2 * VR * 800 + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
